// File: rtl/sa_feeder_if.sv
// Bus between the systolic-array feeder and its host/array: matrix write port,
// sequence control and the skewed activation / weight lanes.
interface sa_feeder_if;
    logic       wr_en;
    logic       wr_sel;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic       busy;
    logic       done;
    logic       P1_en;
    logic [7:0] A_out_1;
    logic [7:0] A_out_2;
    logic [7:0] A_out_3;
    logic [7:0] B_out_1;
    logic [7:0] B_out_2;
    logic [7:0] B_out_3;

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, start,
        input  busy, done, P1_en, A_out_1, A_out_2, A_out_3, B_out_1, B_out_2, B_out_3
    );

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, start,
        output busy, done, P1_en, A_out_1, A_out_2, A_out_3, B_out_1, B_out_2, B_out_3
    );
endinterface

// File: rtl/sa_feeder.sv
// 3x3 systolic-array feeder: buffers A and B, preloads B rows, then streams A
// along a diagonal skew so lane j lags lane 1 by j-1 cycles.
module sa_feeder (
    input logic        clk,
    input logic        rst,
    sa_feeder_if.slave bus
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StLoadB = 3'd1;
    localparam logic [2:0] StFeedA = 3'd2;
    localparam logic [2:0] StDrain = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    logic [2:0] state_q, state_d;
    logic [2:0] k_q, k_d;

    logic [7:0] a_mem [9];
    logic [7:0] b_mem [9];
    logic       wr_ok;

    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       p1_en_q, p1_en_d;
    logic [7:0] a_out_q [3];
    logic [7:0] a_out_d [3];
    logic [7:0] b_out_q [3];
    logic [7:0] b_out_d [3];

    function automatic logic [3:0] elem_idx(input logic [2:0] row, input logic [1:0] col);
        return ({1'b0, row} * 4'd3) + {2'b00, col};
    endfunction

    // Writes only land while idle and no sequence is being requested.
    assign wr_ok = bus.wr_en && (state_q == StIdle) && !bus.start && (bus.wr_addr <= 4'd8);

    always_comb begin
        state_d = state_q;
        k_d     = k_q + 3'd1;
        case (state_q)
            StIdle: begin
                k_d = 3'd0;
                if (bus.start) state_d = StLoadB;
            end
            StLoadB: begin
                if (k_q == 3'd2) begin
                    state_d = StFeedA;
                    k_d     = 3'd0;
                end
            end
            StFeedA: begin
                if (k_q == 3'd4) begin
                    state_d = StDrain;
                    k_d     = 3'd0;
                end
            end
            StDrain: begin
                if (k_q == 3'd2) begin
                    state_d = StDone;
                    k_d     = 3'd0;
                end
            end
            StDone: begin
                state_d = StIdle;
                k_d     = 3'd0;
            end
            default: begin
                state_d = StIdle;
                k_d     = 3'd0;
            end
        endcase
    end

    // Outputs are decoded from the state/phase being entered so they register
    // on the same edge as the transition.
    always_comb begin
        busy_d  = (state_d == StLoadB) || (state_d == StFeedA) || (state_d == StDrain);
        done_d  = (state_d == StDone);
        p1_en_d = (state_d == StLoadB);
        for (int j = 0; j < 3; j++) begin
            a_out_d[j] = 8'h00;
            b_out_d[j] = 8'h00;
            if ((state_d == StLoadB) && (k_d <= 3'd2)) begin
                b_out_d[j] = b_mem[elem_idx(k_d, 2'(j))];
            end
            if ((state_d == StFeedA) && (k_d >= 3'(j)) && ((k_d - 3'(j)) <= 3'd2)) begin
                a_out_d[j] = a_mem[elem_idx(k_d - 3'(j), 2'(j))];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            k_q     <= 3'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 9; i++) begin
                a_mem[i] <= 8'h00;
                b_mem[i] <= 8'h00;
            end
        end else if (wr_ok) begin
            if (bus.wr_sel) begin
                b_mem[bus.wr_addr] <= bus.wr_data;
            end else begin
                a_mem[bus.wr_addr] <= bus.wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            p1_en_q <= 1'b0;
            for (int j = 0; j < 3; j++) begin
                a_out_q[j] <= 8'h00;
                b_out_q[j] <= 8'h00;
            end
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            p1_en_q <= p1_en_d;
            for (int j = 0; j < 3; j++) begin
                a_out_q[j] <= a_out_d[j];
                b_out_q[j] <= b_out_d[j];
            end
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.P1_en   = p1_en_q;
    assign bus.A_out_1 = a_out_q[0];
    assign bus.A_out_2 = a_out_q[1];
    assign bus.A_out_3 = a_out_q[2];
    assign bus.B_out_1 = b_out_q[0];
    assign bus.B_out_2 = b_out_q[1];
    assign bus.B_out_3 = b_out_q[2];

endmodule

// File: tb/tb_sa_feeder.sv
// Scoreboard bench for sa_feeder: the driver pushes whole expected sequences
// built from shadow matrices; a negedge monitor pops and compares.
module tb_sa_feeder;

    logic clk;
    logic rst;

    sa_feeder_if bus ();

    sa_feeder u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       p1;
        logic       busy;
        logic       done;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] b3;
    } frame_t;

    frame_t     exp_q[$];
    int         done_cyc[$];
    logic [7:0] ref_a [9];
    logic [7:0] ref_b [9];
    int         seq_pos;
    int         total;
    int         bad;
    int         cyc;
    int         busy_run;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic frame_t dut_frame();
        frame_t f;
        f.p1   = bus.P1_en;
        f.busy = bus.busy;
        f.done = bus.done;
        f.a1   = bus.A_out_1;
        f.a2   = bus.A_out_2;
        f.a3   = bus.A_out_3;
        f.b1   = bus.B_out_1;
        f.b2   = bus.B_out_2;
        f.b3   = bus.B_out_3;
        return f;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    // Expected response of one sequence: 3 weight rows, 5 skewed activation
    // beats, 3 empty drain beats, then the done beat.
    function automatic void push_sequence();
        frame_t     f;
        logic [7:0] lane [3];
        for (int t = 0; t < 12; t++) begin
            f = '0;
            for (int j = 0; j < 3; j++) lane[j] = 8'h00;
            if (t < 3) begin
                f.p1 = 1'b1;
                f.busy = 1'b1;
                f.b1 = ref_b[t*3 + 0];
                f.b2 = ref_b[t*3 + 1];
                f.b3 = ref_b[t*3 + 2];
            end else if (t < 8) begin
                f.busy = 1'b1;
                for (int j = 0; j < 3; j++) begin
                    if ((t - 3 - j) >= 0 && (t - 3 - j) <= 2) lane[j] = ref_a[(t - 3 - j)*3 + j];
                end
                f.a1 = lane[0];
                f.a2 = lane[1];
                f.a3 = lane[2];
            end else if (t < 11) begin
                f.busy = 1'b1;
            end else begin
                f.done = 1'b1;
            end
            exp_q.push_back(f);
        end
    endfunction

    task automatic step(input bit st, input bit we, input bit sel, input logic [3:0] addr,
                        input logic [7:0] data);
        bus.start   = st;
        bus.wr_en   = we;
        bus.wr_sel  = sel;
        bus.wr_addr = addr;
        bus.wr_data = data;
        @(posedge clk);
        if (seq_pos < 0) begin
            if (st) begin
                push_sequence();
                seq_pos = 0;
            end else if (we && addr <= 4'd8) begin
                if (sel) ref_b[addr] = data;
                else     ref_a[addr] = data;
            end
        end else begin
            seq_pos = (seq_pos == 11) ? -1 : seq_pos + 1;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    endtask

    task automatic wr(input bit sel, input logic [3:0] addr, input logic [7:0] data);
        step(1'b0, 1'b1, sel, addr, data);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 60) begin
            idle(1);
            guard++;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        idle(2);
    endtask

    task automatic clear_model();
        exp_q.delete();
        seq_pos = -1;
        for (int i = 0; i < 9; i++) begin
            ref_a[i] = 8'h00;
            ref_b[i] = 8'h00;
        end
    endtask

    always @(negedge clk) begin
        frame_t f;
        cyc++;
        if (!rst) begin
            check("reset_outputs", 64'(dut_frame()), 64'd0);
            busy_run = 0;
        end else begin
            if (bus.busy) begin
                busy_run++;
            end else if (busy_run > 0) begin
                check("busy_span", 64'(busy_run), 64'd11);
                busy_run = 0;
            end
            if (bus.done) done_cyc.push_back(cyc);
            if (bus.busy || bus.done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 64'(dut_frame()), 64'd0);
                end else begin
                    f = exp_q.pop_front();
                    check("frame", 64'(dut_frame()), 64'(f));
                end
            end else begin
                check("idle_outputs", 64'(dut_frame()), 64'd0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        total = 0;
        bad = 0;
        cyc = 0;
        busy_run = 0;
        rst = 1'b0;
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        bus.wr_sel = 1'b0;
        bus.wr_addr = 4'd0;
        bus.wr_data = 8'h00;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);
        check("post_reset_outputs", 64'(dut_frame()), 64'd0);

        // B = 1..9, A = diag(1,2,3)
        for (int i = 0; i < 9; i++) wr(1'b1, 4'(i), 8'(i + 1));
        for (int i = 0; i < 9; i++) wr(1'b0, 4'(i), (i % 4 == 0) ? 8'(i / 4 + 1) : 8'h00);
        step(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
        drain();

        // A = 1..9
        for (int i = 0; i < 9; i++) wr(1'b0, 4'(i), 8'(i + 1));
        step(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
        drain();

        // Out-of-range writes and writes while busy must be dropped.
        wr(1'b0, 4'd12, 8'hEE);
        wr(1'b1, 4'd15, 8'hDD);
        step(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
        for (int i = 0; i < 10; i++) wr(i[0], 4'(i % 9), 8'hC0 + 8'(i));
        drain();
        step(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
        drain();

        // start with wr_en in the same cycle; start pulses during FEED_A.
        step(1'b1, 1'b1, 1'b0, 4'd0, 8'hAA);
        idle(3);
        step(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
        idle(1);
        step(1'b1, 1'b1, 1'b1, 4'd4, 8'h55);
        drain();

        // Randomised writes and start requests.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 11) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        end
        drain();

        // Reset at FEED_A k=2 aborts the sequence and clears the buffers.
        step(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
        idle(5);
        rst = 1'b0;
        #1;
        check("async_reset_outputs", 64'(dut_frame()), 64'd0);
        clear_model();
        idle(2);
        rst = 1'b1;
        idle(2);
        step(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
        drain();

        // start held high: back-to-back sequences 13 cycles apart.
        for (int i = 0; i < 9; i++) wr(1'b0, 4'(i), 8'(8'h10 + 8'(i)));
        for (int i = 0; i < 9; i++) wr(1'b1, 4'(i), 8'(8'h90 - 8'(i)));
        done_cyc.delete();
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
        drain();
        check("held_start_done_count", 64'(done_cyc.size()), 64'd3);
        for (int i = 1; i < done_cyc.size(); i++) begin
            check("done_spacing", 64'(done_cyc[i] - done_cyc[i-1]), 64'd13);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
